wsc_power_supervisor: RTL and testbench

- Parametrised successor to the fixed power-up pulse in the capture top level.
- Generates the console power-button pulse after a programmable startup delay, then supervises vblank activity with a watchdog.
- On loss of video, or when forced, it re-issues the power pulse with bounded retries and reports video-valid, state and fault status.
- Sits in the pxlClk domain beside videoCapture. powerOut drives the console power pin; videoValid may gate imageGen's output to a blank frame.

---
 rtl/wsc_power_supervisor.sv | 169 ++++++++++++++++
 tb/tb_wsc_power_supervisor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wsc_power_supervisor.sv
// Console power-button sequencer with vblank watchdog: delayed power pulse,
// video supervision, bounded re-power retries and a latched fault state.
module wsc_power_supervisor #(
    parameter int POWERUPCYCLES   = 2700000,
    parameter int STARTUP_DELAY   = 1024,
    parameter int WATCHDOG_CYCLES = 4000000,
    parameter int PULSE_GAP       = 2700000,
    parameter int MAX_RETRIES     = 3,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                             pxlClk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             vblank,
    input  logic                             forceRepower,
    output logic                             powerOut,
    output logic                             videoValid,
    output logic                             fault,
    output logic [2:0]                       state,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retryCnt
);

    localparam int RW      = $clog2(MAX_RETRIES + 1);
    localparam int MAX_A   = (POWERUPCYCLES > STARTUP_DELAY) ? POWERUPCYCLES : STARTUP_DELAY;
    localparam int MAX_B   = (WATCHDOG_CYCLES > PULSE_GAP) ? WATCHDOG_CYCLES : PULSE_GAP;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(STARTUP_DELAY - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(POWERUPCYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(WATCHDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(PULSE_GAP - 1);
    localparam logic [RW-1:0]    RETRY_MAX  = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DELAY      = 3'd1,
        ST_PULSE      = 3'd2,
        ST_WAIT_VIDEO = 3'd3,
        ST_RUN        = 3'd4,
        ST_BACKOFF    = 3'd5,
        ST_FAULT      = 3'd6
    } state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [RW-1:0]          retry_reg;
    logic                   power_reg;
    logic                   valid_reg;
    logic                   fault_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   vb_prev_reg;
    logic                   vb_rise;

    // vblank is asynchronous: shift it through the synchroniser chain first
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = vblank;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge pxlClk) begin
        if (rst) begin
            sync_reg    <= '0;
            vb_prev_reg <= 1'b0;
        end else begin
            sync_reg    <= sync_next;
            vb_prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign vb_rise = sync_reg[SYNC_STAGES-1] & ~vb_prev_reg;

    always_ff @(posedge pxlClk) begin
        if (rst || !enable) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            retry_reg <= '0;
            power_reg <= 1'b0;
            valid_reg <= 1'b0;
            fault_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_DELAY;
                    cnt_reg   <= '0;
                end
                ST_DELAY: begin
                    if (cnt_reg == DELAY_LAST) begin
                        state_reg <= ST_PULSE;
                        cnt_reg   <= '0;
                        power_reg <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_reg == PULSE_LAST) begin
                        state_reg <= ST_WAIT_VIDEO;
                        cnt_reg   <= '0;
                        power_reg <= 1'b0;
                    end
                end
                ST_WAIT_VIDEO: begin
                    if (vb_rise) begin
                        state_reg <= ST_RUN;
                        cnt_reg   <= '0;
                        retry_reg <= '0;
                        valid_reg <= 1'b1;
                    end else if (cnt_reg == WD_LAST) begin
                        cnt_reg <= '0;
                        if (retry_reg < RETRY_MAX) begin
                            state_reg <= ST_BACKOFF;
                            retry_reg <= retry_reg + 1'b1;
                        end else begin
                            state_reg <= ST_FAULT;
                            fault_reg <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // A forced re-power is not a video failure, so it never counts as a retry
                    if (forceRepower) begin
                        state_reg <= ST_BACKOFF;
                        cnt_reg   <= '0;
                        valid_reg <= 1'b0;
                    end else if (vb_rise) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == WD_LAST) begin
                        state_reg <= ST_BACKOFF;
                        cnt_reg   <= '0;
                        valid_reg <= 1'b0;
                        retry_reg <= retry_reg + 1'b1;
                    end
                end
                ST_BACKOFF: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_reg <= ST_PULSE;
                        cnt_reg   <= '0;
                        power_reg <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    cnt_reg <= cnt_reg;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    retry_reg <= '0;
                    power_reg <= 1'b0;
                    valid_reg <= 1'b0;
                    fault_reg <= 1'b0;
                end
            endcase
        end
    end

    assign powerOut   = power_reg;
    assign videoValid = valid_reg;
    assign fault      = fault_reg;
    assign state      = state_reg;
    assign retryCnt   = retry_reg;

endmodule

// File: tb/tb_wsc_power_supervisor.sv
// Scoreboard bench for wsc_power_supervisor: expected snapshots are queued per
// clock edge as stimulus is planned and compared when that edge's outputs appear.
module tb_wsc_power_supervisor;

    localparam int RW = 2;

    logic          pxlClk;
    logic          rst;
    logic          enable;
    logic          vblank;
    logic          forceRepower;
    logic          powerOut;
    logic          videoValid;
    logic          fault;
    logic [2:0]    state;
    logic [RW-1:0] retryCnt;

    wsc_power_supervisor #(
        .POWERUPCYCLES  (4),
        .STARTUP_DELAY  (3),
        .WATCHDOG_CYCLES(20),
        .PULSE_GAP      (5),
        .MAX_RETRIES    (2),
        .SYNC_STAGES    (2)
    ) dut (
        .pxlClk      (pxlClk),
        .rst         (rst),
        .enable      (enable),
        .vblank      (vblank),
        .forceRepower(forceRepower),
        .powerOut    (powerOut),
        .videoValid  (videoValid),
        .fault       (fault),
        .state       (state),
        .retryCnt    (retryCnt)
    );

    typedef struct {
        int    at_edge;
        string tag;
        int    st;
        int    po;
        int    vv;
        int    flt;
        int    rc;
        int    pulses;
    } exp_t;

    exp_t sb_q[$];
    int   edge_cnt     = 0;
    int   pulse_cnt    = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic po_prev      = 1'b0;

    initial begin
        pxlClk = 1'b0;
        forever #5 pxlClk = ~pxlClk;
    end

    initial forever begin
        @(posedge pxlClk);
        edge_cnt = edge_cnt + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run = tests_run + 1;
        if (got != exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic push_exp(input int at_edge, input string tag, input int st, input int po,
                            input int vv, input int flt, input int rc, input int pulses);
        exp_t e;
        e.at_edge = at_edge;
        e.tag     = tag;
        e.st      = st;
        e.po      = po;
        e.vv      = vv;
        e.flt     = flt;
        e.rc      = rc;
        e.pulses  = pulses;
        sb_q.push_back(e);
    endtask

    // Inputs change just after a falling edge, so they take effect on the next rising edge
    task automatic wait_until(input int e);
        while (edge_cnt < e) @(negedge pxlClk);
        #1;
    endtask

    // Monitor: counts powerOut pulses and compares queued snapshots on the falling edge
    initial forever begin
        exp_t e;
        @(negedge pxlClk);
        if (powerOut && !po_prev) pulse_cnt = pulse_cnt + 1;
        po_prev = powerOut;
        while (sb_q.size() > 0 && sb_q[0].at_edge <= edge_cnt) begin
            e = sb_q.pop_front();
            check_eq({e.tag, ".edge"}, edge_cnt, e.at_edge);
            check_eq({e.tag, ".state"}, int'(state), e.st);
            check_eq({e.tag, ".powerOut"}, int'(powerOut), e.po);
            check_eq({e.tag, ".videoValid"}, int'(videoValid), e.vv);
            check_eq({e.tag, ".fault"}, int'(fault), e.flt);
            check_eq({e.tag, ".retryCnt"}, int'(retryCnt), e.rc);
            check_eq({e.tag, ".pulses"}, pulse_cnt, e.pulses);
            $display("[TB] edge %0d %s: state=%0d powerOut=%0d videoValid=%0d fault=%0d retryCnt=%0d pulses=%0d",
                     edge_cnt, e.tag, state, powerOut, videoValid, fault, retryCnt, pulse_cnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, state=%0d", state);
        $fatal(1);
    end

    initial begin
        int b1, b2, b3, b4;
        rst          = 1'b1;
        enable       = 1'b1;
        vblank       = 1'b0;
        forceRepower = 1'b0;
        b1 = 2;

        // Cold start, lock, video loss and retry exhaustion in one continuous run
        push_exp(2,       "reset",         0, 0, 0, 0, 0, 0);
        push_exp(b1 + 3,  "delay",         1, 0, 0, 0, 0, 0);
        push_exp(b1 + 4,  "pulse_on",      2, 1, 0, 0, 0, 1);
        push_exp(b1 + 7,  "pulse_hold",    2, 1, 0, 0, 0, 1);
        push_exp(b1 + 8,  "wait_video",    3, 0, 0, 0, 0, 1);
        push_exp(b1 + 10, "pre_lock",      3, 0, 0, 0, 0, 1);
        push_exp(b1 + 11, "lock",          4, 0, 1, 0, 0, 1);
        push_exp(b1 + 225,"locked_long",   4, 0, 1, 0, 0, 1);
        push_exp(b1 + 240,"pre_loss",      4, 0, 1, 0, 0, 1);
        push_exp(b1 + 241,"video_loss",    5, 0, 0, 0, 1, 1);
        push_exp(b1 + 245,"backoff_end",   5, 0, 0, 0, 1, 1);
        push_exp(b1 + 246,"retry1_on",     2, 1, 0, 0, 1, 2);
        push_exp(b1 + 249,"retry1_hold",   2, 1, 0, 0, 1, 2);
        push_exp(b1 + 250,"retry1_off",    3, 0, 0, 0, 1, 2);
        push_exp(b1 + 270,"retry2_backoff",5, 0, 0, 0, 2, 2);
        push_exp(b1 + 275,"retry2_on",     2, 1, 0, 0, 2, 3);
        push_exp(b1 + 298,"last_wait",     3, 0, 0, 0, 2, 3);
        push_exp(b1 + 299,"fault",         6, 0, 0, 1, 2, 3);
        push_exp(b1 + 400,"fault_hold",    6, 0, 0, 1, 2, 3);
        push_exp(b1 + 401,"rst_in_fault",  0, 0, 0, 0, 0, 3);

        wait_until(b1);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            wait_until(b1 + 8 + 15 * k);
            vblank = 1'b1;
            wait_until(b1 + 11 + 15 * k);
            vblank = 1'b0;
        end
        wait_until(b1 + 400);
        rst = 1'b1;
        wait_until(b1 + 401);
        rst = 1'b0;

        // Fresh start with no video at all; force in WAIT_VIDEO must be ignored
        b2 = b1 + 401;
        push_exp(b2 + 4,   "ns_pulse1",     2, 1, 0, 0, 0, 4);
        push_exp(b2 + 8,   "ns_wait1",      3, 0, 0, 0, 0, 4);
        push_exp(b2 + 13,  "force_ignored", 3, 0, 0, 0, 0, 4);
        push_exp(b2 + 27,  "ns_pre_to1",    3, 0, 0, 0, 0, 4);
        push_exp(b2 + 28,  "ns_backoff1",   5, 0, 0, 0, 1, 4);
        push_exp(b2 + 33,  "ns_pulse2",     2, 1, 0, 0, 1, 5);
        push_exp(b2 + 57,  "ns_backoff2",   5, 0, 0, 0, 2, 5);
        push_exp(b2 + 62,  "ns_pulse3",     2, 1, 0, 0, 2, 6);
        push_exp(b2 + 66,  "ns_wait3",      3, 0, 0, 0, 2, 6);
        push_exp(b2 + 86,  "ns_fault",      6, 0, 0, 1, 2, 6);
        push_exp(b2 + 200, "ns_fault_hold", 6, 0, 0, 1, 2, 6);
        push_exp(b2 + 201, "enable_off",    0, 0, 0, 0, 0, 6);

        wait_until(b2 + 12);
        forceRepower = 1'b1;
        wait_until(b2 + 13);
        forceRepower = 1'b0;
        wait_until(b2 + 200);
        enable = 1'b0;
        wait_until(b2 + 201);
        enable = 1'b1;

        // Drop enable while the power pulse is high
        b3 = b2 + 201;
        push_exp(b3 + 5, "mid_pulse",   2, 1, 0, 0, 0, 7);
        push_exp(b3 + 6, "abort_pulse", 0, 0, 0, 0, 0, 7);
        wait_until(b3 + 5);
        enable = 1'b0;
        wait_until(b3 + 6);
        enable = 1'b1;

        // Force coinciding with RUN timeout, then reset mid-pulse
        b4 = b3 + 6;
        push_exp(b4 + 4,  "g_pulse",        2, 1, 0, 0, 0, 8);
        push_exp(b4 + 11, "g_lock",         4, 0, 1, 0, 0, 8);
        push_exp(b4 + 30, "g_pre_timeout",  4, 0, 1, 0, 0, 8);
        push_exp(b4 + 31, "force_timeout",  5, 0, 0, 0, 0, 8);
        push_exp(b4 + 36, "force_pulse",    2, 1, 0, 0, 0, 9);
        push_exp(b4 + 37, "force_pulse_hi", 2, 1, 0, 0, 0, 9);
        push_exp(b4 + 38, "rst_mid_pulse",  0, 0, 0, 0, 0, 9);
        wait_until(b4 + 8);
        vblank = 1'b1;
        wait_until(b4 + 11);
        vblank = 1'b0;
        wait_until(b4 + 30);
        forceRepower = 1'b1;
        wait_until(b4 + 31);
        forceRepower = 1'b0;
        wait_until(b4 + 37);
        rst = 1'b1;
        wait_until(b4 + 38);
        rst = 1'b0;

        wait_until(b4 + 42);
        check_eq("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
